// File: rtl/adder_pkg.sv
// Shared width constant and word type for the N-bit adder slice.
package adder_pkg;

  localparam int ADDER_W = 32;

  typedef logic [ADDER_W-1:0] word_t;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder, the ripple cell chained by adder_n_core.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  // Plain gate equations so any X/Z on an input reaches the outputs untouched
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule : full_adder

// File: rtl/adder_n_core.sv
// N-bit ripple-carry adder with a zero-latency result and a registered copy.
// Optional build macro ADDER_FLAGS_EN adds overflow/zero/negative flags and
// their registered copies.
module adder_n_core
  import adder_pkg::*;
#(
  parameter int N = ADDER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic [N-1:0] sum_q,
  output logic         c_out_q
`ifdef ADDER_FLAGS_EN
  ,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         overflow_q,
  output logic         zero_q,
  output logic         negative_q
`endif
);

  // carry[i] is the carry into bit i; carry[N] leaves the MSB
  logic [N:0] carry;

  logic [N-1:0] sum_d;
  logic         c_out_d;

  assign carry[0] = c_in;

  // Ripple chain: each cell takes the previous cell's carry-out
  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .sum   (sum[i]),
      .c_out (carry[i+1])
    );
  end

  assign c_out = carry[N];

`ifdef ADDER_FLAGS_EN
  logic overflow_d;
  logic zero_d;
  logic negative_d;

  // Signed overflow is a mismatch between the carries into and out of the MSB
  assign overflow = carry[N-1] ^ carry[N];
  assign zero     = (sum == '0);
  assign negative = sum[N-1];

  // Next flag values: load on enable, otherwise hold
  always_comb begin
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    if (en) begin
      overflow_d = overflow;
      zero_d     = zero;
      negative_d = negative;
    end
  end

  // Flag registers, cleared asynchronously alongside the sum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end
`endif

  // Next registered result: capture the live sum on enable, otherwise hold
  always_comb begin
    sum_d   = sum_q;
    c_out_d = c_out_q;
    if (en) begin
      sum_d   = sum;
      c_out_d = c_out;
    end
  end

  // Result register with asynchronous clear; deassertion arrives pre-synchronized
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

endmodule : adder_n_core

// File: tb/tb_adder_n_core.sv
// Directed and random checks of adder_n_core at widths 32, 8 and 1.
module tb_adder_n_core;
  import adder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  word_t       a;
  word_t       b;
  logic        c_in;

  word_t       sum;
  logic        c_out;
  word_t       sum_q;
  logic        c_out_q;

  logic [7:0]  sum8;
  logic        c_out8;
  logic [7:0]  sum_q8;
  logic        c_out_q8;

  logic [0:0]  sum1;
  logic        c_out1;
  logic [0:0]  sum_q1;
  logic        c_out_q1;

`ifdef ADDER_FLAGS_EN
  logic overflow, zero, negative, overflow_q, zero_q, negative_q;
  logic overflow8, zero8, negative8, overflow_q8, zero_q8, negative_q8;
  logic overflow1, zero1, negative1, overflow_q1, zero_q1, negative_q1;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  adder_n_core #(.N(32)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .sum     (sum),
    .c_out   (c_out),
    .sum_q   (sum_q),
    .c_out_q (c_out_q)
`ifdef ADDER_FLAGS_EN
    ,
    .overflow   (overflow),
    .zero       (zero),
    .negative   (negative),
    .overflow_q (overflow_q),
    .zero_q     (zero_q),
    .negative_q (negative_q)
`endif
  );

  adder_n_core #(.N(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .a       (a[7:0]),
    .b       (b[7:0]),
    .c_in    (c_in),
    .sum     (sum8),
    .c_out   (c_out8),
    .sum_q   (sum_q8),
    .c_out_q (c_out_q8)
`ifdef ADDER_FLAGS_EN
    ,
    .overflow   (overflow8),
    .zero       (zero8),
    .negative   (negative8),
    .overflow_q (overflow_q8),
    .zero_q     (zero_q8),
    .negative_q (negative_q8)
`endif
  );

  adder_n_core #(.N(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .a       (a[0:0]),
    .b       (b[0:0]),
    .c_in    (c_in),
    .sum     (sum1),
    .c_out   (c_out1),
    .sum_q   (sum_q1),
    .c_out_q (c_out_q1)
`ifdef ADDER_FLAGS_EN
    ,
    .overflow   (overflow1),
    .zero       (zero1),
    .negative   (negative1),
    .overflow_q (overflow_q1),
    .zero_q     (zero_q1),
    .negative_q (negative_q1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input vector and let the combinational path settle
  task automatic applyStimulus(input word_t ia, input word_t ib, input logic ic, input logic ie);
    a    = ia;
    b    = ib;
    c_in = ic;
    en   = ie;
    #1;
  endtask

  // One comparison: count it, and on mismatch count and report it
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin : main
    logic [32:0] exp32;
    logic [8:0]  exp8;
    logic [1:0]  exp1;

    rst_n = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);

    // Reset state, and 0+0+0 on the live path while reset is held
    checkOutput("reset_sum_q",   64'(sum_q),   64'h0);
    checkOutput("reset_c_out_q", 64'(c_out_q), 64'h0);
    checkOutput("zero_plus_zero", 64'({c_out, sum}), 64'h0);
`ifdef ADDER_FLAGS_EN
    checkOutput("reset_flags_q", 64'({overflow_q, zero_q, negative_q}), 64'h0);
    checkOutput("zero_flags",    64'({overflow, zero, negative}), 64'b010);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    // Directed combinational vectors
    applyStimulus(32'hA0040002, 32'hD0040004, 1'b1, 1'b0);
    checkOutput("vec_mixed", 64'({c_out, sum}), 64'h1_7008_0007);
`ifdef ADDER_FLAGS_EN
    checkOutput("vec_mixed_flags", 64'({overflow, zero, negative}), 64'b100);
`endif

    applyStimulus(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    checkOutput("full_wrap", 64'({c_out, sum}), 64'h1_0000_0000);
`ifdef ADDER_FLAGS_EN
    checkOutput("full_wrap_flags", 64'({overflow, zero, negative}), 64'b010);
`endif

    applyStimulus(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
    checkOutput("signed_ovf", 64'({c_out, sum}), 64'h0_8000_0000);
`ifdef ADDER_FLAGS_EN
    checkOutput("signed_ovf_flags", 64'({overflow, zero, negative}), 64'b101);
`endif

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    checkOutput("max_max_one", 64'({c_out, sum}), 64'h1_FFFF_FFFF);
`ifdef ADDER_FLAGS_EN
    checkOutput("max_max_one_flags", 64'({overflow, zero, negative}), 64'b001);
`endif

    // Capture then hold
    @(negedge clk);
    applyStimulus(32'd5, 32'd3, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("capture_sum_q",   64'(sum_q),   64'd8);
    checkOutput("capture_c_out_q", 64'(c_out_q), 64'd0);

    applyStimulus(32'd1, 32'd3, 1'b0, 1'b0);
    checkOutput("hold_live_sum", 64'(sum), 64'd4);
    @(posedge clk);
    #1;
    checkOutput("hold_sum_q", 64'(sum_q), 64'd8);

    // Mid-cycle reset clears the register at once; live path keeps working
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_sum_q",   64'(sum_q),   64'h0);
    checkOutput("async_rst_c_out_q", 64'(c_out_q), 64'h0);
    checkOutput("rst_live_sum",      64'(sum),     64'd4);

    // Reset dominates an enabled edge
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("rst_over_en_sum_q", 64'({c_out_q, sum_q}), 64'h0);
    checkOutput("rst_live_max",      64'({c_out, sum}),     64'h1_FFFF_FFFF);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("cap_max_q", 64'({c_out_q, sum_q}), 64'h1_FFFF_FFFF);
`ifdef ADDER_FLAGS_EN
    checkOutput("cap_max_flags_q", 64'({overflow_q, zero_q, negative_q}), 64'b001);
`endif

    @(negedge clk);
    applyStimulus(32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("cap_wrap_q", 64'({c_out_q, sum_q}), 64'h1_0000_0000);
`ifdef ADDER_FLAGS_EN
    checkOutput("cap_wrap_flags_q", 64'({overflow_q, zero_q, negative_q}), 64'b010);
`endif

    @(negedge clk);
    applyStimulus(32'h7FFFFFFF, 32'h1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("cap_ovf_q", 64'({c_out_q, sum_q}), 64'h0_8000_0000);
`ifdef ADDER_FLAGS_EN
    checkOutput("cap_ovf_flags_q", 64'({overflow_q, zero_q, negative_q}), 64'b101);
`endif

    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_q", 64'({c_out_q, sum_q}), 64'h0);
`ifdef ADDER_FLAGS_EN
    checkOutput("rst2_flags_q", 64'({overflow_q, zero_q, negative_q}), 64'b000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;

    // Random vectors at all three widths against an independent sum model
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(word_t'($urandom), word_t'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      exp32 = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
      exp8  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'b0, c_in};
      exp1  = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, c_in};
      checkOutput("rand_n32", 64'({c_out, sum}),   64'(exp32));
      checkOutput("rand_n8",  64'({c_out8, sum8}), 64'(exp8));
      checkOutput("rand_n1",  64'({c_out1, sum1}), 64'(exp1));
`ifdef ADDER_FLAGS_EN
      checkOutput("rand_n32_flags", 64'({overflow, zero, negative}),
                  64'({(a[31] == b[31]) && (exp32[31] != a[31]), exp32[31:0] == 32'h0, exp32[31]}));
      checkOutput("rand_n8_flags", 64'({overflow8, zero8, negative8}),
                  64'({(a[7] == b[7]) && (exp8[7] != a[7]), exp8[7:0] == 8'h0, exp8[7]}));
      checkOutput("rand_n1_flags", 64'({overflow1, zero1, negative1}),
                  64'({(a[0] == b[0]) && (exp1[0] != a[0]), exp1[0] == 1'b0, exp1[0]}));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_adder_n_core
